// File: rtl/sparse_pkg.sv
// Shared types and helpers for the 2:4 structured-sparsity weight path.
// Dense groups carry four signed weights; sparse packets carry the two survivors plus their indices.
package sparse_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int GROUP_SIZE = 4;
  localparam int IDX_WIDTH  = 2;

  typedef logic signed [DATA_WIDTH-1:0] weight_t;
  typedef weight_t [GROUP_SIZE-1:0]     dense_group_t;
  typedef logic [IDX_WIDTH-1:0]         idx_t;
  typedef logic [DATA_WIDTH:0]          mag_t;

  typedef struct packed {
    weight_t val_1;
    weight_t val_0;
    idx_t    idx_1;
    idx_t    idx_0;
  } sparse_packet_t;

  // One extra bit so the most negative weight still has a representable magnitude.
  function automatic mag_t abs_mag(input weight_t w);
    mag_t ext;
    ext = {w[DATA_WIDTH-1], w};
    return ext[DATA_WIDTH] ? (~ext + mag_t'(1)) : ext;
  endfunction

endpackage

// File: rtl/sparse_weight_encoder_if.sv
// Dense-in / sparse-out valid-ready bus of the weight encoder.
// The encoder takes the slave side; the weight source and PE loader take the master side.
interface sparse_weight_encoder_if;
  import sparse_pkg::*;

  logic           in_valid;
  logic           in_ready;
  dense_group_t   in_group;
  logic           out_valid;
  logic           out_ready;
  sparse_packet_t out_pkt;
  logic           out_lossy;

  modport slave (
    input  in_valid, in_group, out_ready,
    output in_ready, out_valid, out_pkt, out_lossy
  );

  modport master (
    output in_valid, in_group, out_ready,
    input  in_ready, out_valid, out_pkt, out_lossy
  );

endinterface

// File: rtl/top2_select.sv
// Combinational top-2 magnitude selection over one dense group.
// A weight survives when fewer than two others outrank it (larger magnitude, or equal magnitude at a lower index).
module top2_select
  import sparse_pkg::*;
(
  input  dense_group_t   group_i,
  output sparse_packet_t pkt_o,
  output logic           lossy_o,
  output logic [1:0]     drop_cnt_o
);

  mag_t                  mag [GROUP_SIZE];
  logic [GROUP_SIZE-1:0] keep;
  logic [2:0]            beaten;
  logic                  found;
  logic [1:0]            drops;

  always_comb begin
    for (int i = 0; i < GROUP_SIZE; i++) begin
      mag[i] = abs_mag(group_i[i]);
    end
  end

  always_comb begin
    keep   = '0;
    beaten = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      beaten = '0;
      for (int j = 0; j < GROUP_SIZE; j++) begin
        if (j != i && (mag[j] > mag[i] || (mag[j] == mag[i] && j < i))) begin
          beaten = beaten + 3'd1;
        end
      end
      keep[i] = (beaten < 3'd2);
    end
  end

  // Scanning upward fills idx_0 first, which keeps idx_0 < idx_1 for free.
  always_comb begin
    pkt_o = '0;
    found = 1'b0;
    drops = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (keep[i]) begin
        if (!found) begin
          pkt_o.idx_0 = idx_t'(i);
          pkt_o.val_0 = group_i[i];
          found       = 1'b1;
        end else begin
          pkt_o.idx_1 = idx_t'(i);
          pkt_o.val_1 = group_i[i];
        end
      end else if (group_i[i] != '0) begin
        drops = drops + 2'd1;
      end
    end
    drop_cnt_o = drops;
    lossy_o    = (drops != 2'd0);
  end

endmodule

// File: rtl/sparse_weight_encoder.sv
// Streaming 2:4 sparsity compressor: input register, top-2 selection, output register, saturating run statistics.
// Two-entry elastic pipeline; in_ready looks through to out_ready so a full pipe still streams one group per cycle.
module sparse_weight_encoder
#(
  parameter int CNT_WIDTH = 16
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  sparse_weight_encoder_if.slave bus,
  input  logic                   stat_clr,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   pruned_count
);
  import sparse_pkg::*;

  logic           s1Valid_q, s1Valid_d;
  dense_group_t   s1Group_q, s1Group_d;
  logic           s2Valid_q, s2Valid_d;
  sparse_packet_t s2Pkt_q, s2Pkt_d;
  logic           s2Lossy_q, s2Lossy_d;
  logic [1:0]     s2Drops_q, s2Drops_d;
  logic [CNT_WIDTH-1:0] pktCount_q, pktCount_d;
  logic [CNT_WIDTH-1:0] prunedCount_q, prunedCount_d;

  sparse_packet_t selPkt;
  logic           selLossy;
  logic [1:0]     selDrops;
  logic           s2Free;
  logic           inReady;
  logic           outFire;
  logic [CNT_WIDTH:0] pktSum;
  logic [CNT_WIDTH:0] prunedSum;

  top2_select u_select (
    .group_i    (s1Group_q),
    .pkt_o      (selPkt),
    .lossy_o    (selLossy),
    .drop_cnt_o (selDrops)
  );

  assign s2Free  = !s2Valid_q || bus.out_ready;
  assign inReady = !s1Valid_q || s2Free;
  assign outFire = s2Valid_q && bus.out_ready;

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Group_d = s1Group_q;
    s2Valid_d = s2Valid_q;
    s2Pkt_d   = s2Pkt_q;
    s2Lossy_d = s2Lossy_q;
    s2Drops_d = s2Drops_q;

    if (inReady) begin
      s1Valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1Group_d = bus.in_group;
      end
    end

    // S2 keeps its payload while stalled so the packet stays stable under backpressure.
    if (s2Free) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Pkt_d   = selPkt;
        s2Lossy_d = selLossy;
        s2Drops_d = selDrops;
      end
    end
  end

  // Sums carry one extra bit; a set carry means the add overflowed and the counter pins at all-ones.
  always_comb begin
    pktSum        = {1'b0, pktCount_q} + (CNT_WIDTH+1)'(1);
    prunedSum     = {1'b0, prunedCount_q} + (CNT_WIDTH+1)'(s2Drops_q);
    pktCount_d    = pktCount_q;
    prunedCount_d = prunedCount_q;
    if (stat_clr) begin
      pktCount_d    = '0;
      prunedCount_d = '0;
    end else if (outFire) begin
      pktCount_d    = pktSum[CNT_WIDTH]    ? '1 : pktSum[CNT_WIDTH-1:0];
      prunedCount_d = prunedSum[CNT_WIDTH] ? '1 : prunedSum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q     <= 1'b0;
      s1Group_q     <= '0;
      s2Valid_q     <= 1'b0;
      s2Pkt_q       <= '0;
      s2Lossy_q     <= 1'b0;
      s2Drops_q     <= '0;
      pktCount_q    <= '0;
      prunedCount_q <= '0;
    end else begin
      s1Valid_q     <= s1Valid_d;
      s1Group_q     <= s1Group_d;
      s2Valid_q     <= s2Valid_d;
      s2Pkt_q       <= s2Pkt_d;
      s2Lossy_q     <= s2Lossy_d;
      s2Drops_q     <= s2Drops_d;
      pktCount_q    <= pktCount_d;
      prunedCount_q <= prunedCount_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = s2Valid_q;
  assign bus.out_pkt   = s2Pkt_q;
  assign bus.out_lossy = s2Lossy_q;
  assign pkt_count     = pktCount_q;
  assign pruned_count  = prunedCount_q;

endmodule

// File: tb/tb_sparse_weight_encoder.sv
// Self-checking bench: a wide-counter and a 2-bit-counter encoder share one stimulus stream,
// and a queue-based reference model predicts packets, handshake readiness and saturating counters.
module tb_sparse_weight_encoder;
  import sparse_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inValid = 1'b0;
  logic outReady = 1'b0;
  logic statClr = 1'b0;
  dense_group_t inGroup = '0;

  always #5 clk = ~clk;

  sparse_weight_encoder_if busWide ();
  sparse_weight_encoder_if busNarrow ();

  assign busWide.in_valid    = inValid;
  assign busWide.in_group    = inGroup;
  assign busWide.out_ready   = outReady;
  assign busNarrow.in_valid  = inValid;
  assign busNarrow.in_group  = inGroup;
  assign busNarrow.out_ready = outReady;

  logic [15:0] pktWide, prunedWide;
  logic [1:0]  pktNarrow, prunedNarrow;

  sparse_weight_encoder #(.CNT_WIDTH(16)) dutWide (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (busWide),
    .stat_clr     (statClr),
    .pkt_count    (pktWide),
    .pruned_count (prunedWide)
  );

  sparse_weight_encoder #(.CNT_WIDTH(2)) dutNarrow (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (busNarrow),
    .stat_clr     (statClr),
    .pkt_count    (pktNarrow),
    .pruned_count (prunedNarrow)
  );

  typedef struct {
    sparse_packet_t pkt;
    logic           lossy;
    int             drops;
    int             stamp;
  } exp_t;

  exp_t expQ[$];
  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  int totPkts = 0;
  int totPruned = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic dense_group_t mk(input int a, input int b, input int c, input int d);
    dense_group_t g;
    g[0] = weight_t'(a);
    g[1] = weight_t'(b);
    g[2] = weight_t'(c);
    g[3] = weight_t'(d);
    return g;
  endfunction

  function automatic sparse_packet_t mkPkt(input int i0, input int i1, input int v0, input int v1);
    sparse_packet_t p;
    p.idx_0 = idx_t'(i0);
    p.idx_1 = idx_t'(i1);
    p.val_0 = weight_t'(v0);
    p.val_1 = weight_t'(v1);
    return p;
  endfunction

  // Reference: pick the largest magnitude, then the largest among the rest; strict '>' favours lower indices.
  function automatic exp_t modelEncode(input dense_group_t g);
    int w[4];
    int m[4];
    int first, second, lo, hi;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      w[i] = int'($signed(g[i]));
      m[i] = (w[i] < 0) ? -w[i] : w[i];
    end
    first = 0;
    for (int i = 1; i < 4; i++) if (m[i] > m[first]) first = i;
    second = (first == 0) ? 1 : 0;
    for (int i = 0; i < 4; i++) if (i != first && m[i] > m[second]) second = i;
    lo = (first < second) ? first : second;
    hi = (first < second) ? second : first;
    e.pkt   = mkPkt(lo, hi, w[lo], w[hi]);
    e.drops = 0;
    for (int i = 0; i < 4; i++) if (i != lo && i != hi && w[i] != 0) e.drops++;
    e.lossy = (e.drops > 0);
    e.stamp = 0;
    return e;
  endfunction

  function automatic int sat(input int v, input int width);
    int maxVal;
    maxVal = (1 << width) - 1;
    return (v > maxVal) ? maxVal : v;
  endfunction

  function automatic dense_group_t randGroup();
    dense_group_t g;
    int w;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 4))
        0:       w = 0;
        1:       w = int'($urandom_range(0, 6)) - 3;
        2:       w = -128;
        3:       w = 127;
        default: w = int'($urandom_range(0, 255)) - 128;
      endcase
      g[i] = weight_t'(w);
    end
    return g;
  endfunction

  // Compare at the falling edge, then advance the model with the handshakes that the rising edge commits.
  initial begin : compareProc
    logic accIn, accOut, clrSnap, expInReady, expOutValid;
    dense_group_t grpSnap;
    exp_t e;
    forever begin
      @(negedge clk);
      accIn = 1'b0;
      accOut = 1'b0;
      clrSnap = 1'b0;
      grpSnap = inGroup;
      if (rst_n) begin
        expInReady  = (expQ.size() < 2) || outReady;
        expOutValid = (expQ.size() > 0) && (cycle > expQ[0].stamp);
        checkOutput("inReady", busWide.in_ready, expInReady);
        checkOutput("outValidWide", busWide.out_valid, expOutValid);
        checkOutput("outValidNarrow", busNarrow.out_valid, expOutValid);
        if (expOutValid) begin
          checkOutput("outPkt", busWide.out_pkt, expQ[0].pkt);
          checkOutput("outLossy", busWide.out_lossy, expQ[0].lossy);
          checkOutput("outPktNarrow", busNarrow.out_pkt, expQ[0].pkt);
        end
        checkOutput("pktCountWide", pktWide, sat(totPkts, 16));
        checkOutput("prunedCountWide", prunedWide, sat(totPruned, 16));
        checkOutput("pktCountNarrow", pktNarrow, sat(totPkts, 2));
        checkOutput("prunedCountNarrow", prunedNarrow, sat(totPruned, 2));
        accIn   = inValid && expInReady;
        accOut  = expOutValid && outReady;
        clrSnap = statClr;
      end
      @(posedge clk);
      cycle++;
      if (!rst_n) begin
        expQ.delete();
        totPkts = 0;
        totPruned = 0;
      end else begin
        if (accOut) begin
          e = expQ.pop_front();
          totPkts++;
          totPruned += e.drops;
        end
        if (clrSnap) begin
          totPkts = 0;
          totPruned = 0;
        end
        if (accIn) begin
          e = modelEncode(grpSnap);
          e.stamp = cycle;
          expQ.push_back(e);
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input dense_group_t g, input logic r);
    @(posedge clk);
    #1;
    inValid = v;
    inGroup = g;
    outReady = r;
  endtask

  task automatic pulseStatClr();
    @(posedge clk);
    #1 statClr = 1'b1;
    @(posedge clk);
    #1 statClr = 1'b0;
  endtask

  task automatic drain();
    applyStimulus(1'b0, '0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("drainIdle", busWide.out_valid, 0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, ".inReady"}, busWide.in_ready, 1);
    checkOutput({name, ".outValid"}, busWide.out_valid, 0);
    checkOutput({name, ".outValidNarrow"}, busNarrow.out_valid, 0);
    checkOutput({name, ".outPkt"}, busWide.out_pkt, 0);
    checkOutput({name, ".outLossy"}, busWide.out_lossy, 0);
    checkOutput({name, ".pktWide"}, pktWide, 0);
    checkOutput({name, ".prunedWide"}, prunedWide, 0);
    checkOutput({name, ".pktNarrow"}, pktNarrow, 0);
    checkOutput({name, ".prunedNarrow"}, prunedNarrow, 0);
  endtask

  // Single group into an idle pipe: accepted on edge N, visible after edge N+1.
  task automatic sendLiteral(input string name, input dense_group_t g,
                             input int i0, input int i1, input int v0, input int v1, input int lz);
    applyStimulus(1'b1, g, 1'b1);
    applyStimulus(1'b0, g, 1'b1);
    @(posedge clk);
    #1;
    checkOutput({name, ".valid"}, busWide.out_valid, 1);
    checkOutput({name, ".idx0"}, busWide.out_pkt.idx_0, i0);
    checkOutput({name, ".idx1"}, busWide.out_pkt.idx_1, i1);
    checkOutput({name, ".val0"}, $signed(busWide.out_pkt.val_0), v0);
    checkOutput({name, ".val1"}, $signed(busWide.out_pkt.val_1), v1);
    checkOutput({name, ".lossy"}, busWide.out_lossy, lz);
  endtask

  initial begin : mainProc
    exp_t pin;
    dense_group_t stallGrp[6];
    int sent;

    #12;
    checkResetValues("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    pin = modelEncode(mk(5, 0, -7, 0));
    checkOutput("pinA.pkt", pin.pkt, mkPkt(0, 2, 5, -7));
    checkOutput("pinA.drops", pin.drops, 0);
    pin = modelEncode(mk(3, -3, 3, 1));
    checkOutput("pinB.pkt", pin.pkt, mkPkt(0, 1, 3, -3));
    checkOutput("pinB.drops", pin.drops, 2);
    pin = modelEncode(mk(1, -128, 127, 2));
    checkOutput("pinC.pkt", pin.pkt, mkPkt(1, 2, -128, 127));
    checkOutput("pinC.lossy", pin.lossy, 1);
    pin = modelEncode(mk(0, 0, 0, 0));
    checkOutput("pinD.pkt", pin.pkt, mkPkt(0, 1, 0, 0));
    checkOutput("pinD.lossy", pin.lossy, 0);

    sendLiteral("grpA", mk(5, 0, -7, 0), 0, 2, 5, -7, 0);
    sendLiteral("grpB", mk(3, -3, 3, 1), 0, 1, 3, -3, 1);
    sendLiteral("grpC", mk(1, -128, 127, 2), 1, 2, -128, 127, 1);
    sendLiteral("grpZero", mk(0, 0, 0, 0), 0, 1, 0, 0, 0);
    drain();
    checkOutput("litPruned", prunedWide, 4);

    // Six-group stream with the sink stalled for three cycles.
    pulseStatClr();
    for (int i = 0; i < 6; i++) stallGrp[i] = randGroup();
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(sent < 6, stallGrp[sent % 6], !(c >= 2 && c <= 4));
      @(negedge clk);
      if (c == 3) checkOutput("stallInReady", busWide.in_ready, 0);
      if (c == 3) checkOutput("stallAccepted", sent, 2);
      if (inValid && busWide.in_ready) sent++;
    end
    checkOutput("stallAllSent", sent, 6);
    drain();
    checkOutput("stallPktCount", pktWide, 6);

    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, randGroup(), $urandom_range(0, 3) != 0);
      statClr = ($urandom_range(0, 39) == 0);
    end
    statClr = 1'b0;
    drain();

    // Asynchronous reset with both stages occupied.
    applyStimulus(1'b1, mk(9, -2, 4, 7), 1'b0);
    applyStimulus(1'b1, mk(-1, 6, 0, 3), 1'b0);
    @(posedge clk);
    #1 inValid = 1'b0;
    checkOutput("preResetValid", busWide.out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    checkResetValues("midReset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    sendLiteral("postReset", mk(0, 4, -4, 4), 1, 2, 4, -4, 1);
    drain();

    // Narrow counters saturate; then a clear lands on the same edge as a handshake.
    pulseStatClr();
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, mk(3, -3, 3, 1), 1'b1);
    drain();
    checkOutput("satPktNarrow", pktNarrow, 3);
    checkOutput("satPrunedNarrow", prunedNarrow, 3);
    checkOutput("satPktWide", pktWide, 5);
    checkOutput("satPrunedWide", prunedWide, 10);
    sendLiteral("clrHs", mk(5, 0, -7, 0), 0, 2, 5, -7, 0);
    statClr = 1'b1;
    @(posedge clk);
    #1 statClr = 1'b0;
    checkOutput("clrPktNarrow", pktNarrow, 0);
    checkOutput("clrPrunedNarrow", prunedNarrow, 0);
    checkOutput("clrPktWide", pktWide, 0);
    checkOutput("clrPrunedWide", prunedWide, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
